ram_param: RTL and testbench
============================

Name: ram_param

Overview:
Parametrised single-clock RAM, successor to the fixed 512x16 RAM. Adds a registered read port with valid strobe and an optional extra output register. Adds a hardware clear sequencer that zeroes every location after reset or on request, and defined read-during-write semantics. Used wherever the Hack-style datapath needs a data or scratch memory of arbitrary width and depth.

Parameters:
WIDTH, 16, data word width in bits
ADDR_W, 9, address width in bits
DEPTH, 2**ADDR_W, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W
OUT_REG, 0, 0 gives read latency 1; 1 adds an output pipeline register for latency 2

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous active-high reset; starts the clear sequence
clear  input  1  single-cycle request to re-zero the whole memory
load  input  1  write enable
address  input  ADDR_W  shared read/write address
in  input  WIDTH  write data
rd_en  input  1  read request
out  output  WIDTH  read data, registered
out_valid  output  1  one-cycle pulse: out holds the data for one read
busy  output  1  high while the clear sequence runs

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset` is synchronous and active-high.
- States are ST_CLEAR and ST_READY, with a clear counter clr_addr of width ADDR_W.
- Reset, sampled at an edge:
  - state <= ST_CLEAR, clr_addr <= 0.
  - out <= 0, out_valid <= 0, pipeline valid <= 0.
  - busy = (state == ST_CLEAR), so busy reads 1 from the first edge with reset high.
- ST_CLEAR:
  - Each edge writes 0 to mem[clr_addr] and increments clr_addr.
  - At clr_addr == DEPTH-1 that write occurs, then the next state is ST_READY. busy is high for exactly DEPTH cycles after reset deasserts.
  - load, rd_en and clear are ignored (dropped, not queued). out_valid stays 0.
  - reset during ST_CLEAR restarts from clr_addr = 0.
- ST_READY, clear == 1:
  - Next state is ST_CLEAR with clr_addr <= 0.
  - load and rd_en in the same cycle are ignored.
  - Any in-flight read in the OUT_REG stage is dropped: out_valid is not pulsed, and out keeps its last value.
- ST_READY, write: with load == 1, mem[address] <= in at the edge.
- ST_READY, read:
  - rd_en == 1 at edge N makes the data visible after edge N (OUT_REG = 0) or after edge N+1 (OUT_REG = 1).
  - out_valid pulses high for one cycle with it.
  - Back-to-back reads are fully pipelined: one result per cycle.
- Output hold: out holds its last read value when no read completes. It is never reset except by reset.
- Read-during-write to the same address in the same cycle is write-first: the read returns `in`.
- Addresses >= DEPTH (only possible when DEPTH < 2**ADDR_W): writes are discarded and reads return 0 with out_valid asserted.
- No combinational path from any input to out, out_valid or busy.
- Memory contents are undefined before the first clear completes. Bench reads of memory only after busy falls.

Decomposition:
- Shared package ram_pkg holds:
  - the state encoding: ST_CLEAR = 1'b0, ST_READY = 1'b1;
  - default constants RAM_WIDTH_DEF = 16 and RAM_ADDR_W_DEF = 9.
- One natural sub-module, ram_clear_seq. It contains the state register and clr_addr counter, and produces busy, the clear-write enable and the clear address.
- The top level holds:
  - the array;
  - the write mux, which selects clear-write or user-write;
  - the read/bypass logic and the optional output stage.

Test Plan (WIDTH=16, ADDR_W=4, DEPTH=16 unless noted):
1. Reset then release -> busy = 1 for exactly 16 cycles and then 0; every address 0..15 reads 0x0000 with one out_valid pulse each.
2. Write 0xBEEF to address 3, then rd_en at address 3 -> with OUT_REG=0, out = 0xBEEF and out_valid = 1 one cycle after rd_en; with OUT_REG=1, two cycles after.
3. Write 0x1234 to address 5 with rd_en at address 5 in the same cycle -> out = 0x1234 (write-first).
4. Fill 0..15 with 0xA000+i, pulse clear, issue load/rd_en while busy -> busy high for 16 cycles, no out_valid during clear, all addresses read 0x0000 afterwards, and the dropped write does not land.
5. Assert reset for 1 cycle when clr_addr = 7 during clear -> clear restarts and busy stays high 16 more cycles.
6. DEPTH=12, ADDR_W=4: write 0x5555 to address 14, read address 14 -> out = 0x0000 with out_valid = 1; address 11 is unaffected.

Source files
------------

// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_pkg
// Brief    : Shared state encoding and default sizes for the parametrised RAM.
// Revision : 1.0
// ============================================================================
package ram_pkg;

   typedef logic [0:0] state_t;

   localparam state_t ST_CLEAR = 1'b0;
   localparam state_t ST_READY = 1'b1;

   localparam int RAM_WIDTH_DEF  = 16;
   localparam int RAM_ADDR_W_DEF = 9;

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_clear_seq.sv
`default_nettype none
// ============================================================================
// Module   : ram_clear_seq
// Brief    : Clear sequencer; sweeps every location with zero after reset/clear.
// Revision : 1.0
// ============================================================================
module ram_clear_seq
   import ram_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W_DEF,
   parameter int DEPTH  = 2**ADDR_W
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_CLEAR;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      if (state_q == ST_CLEAR) begin
         if (clr_addr_q == LAST_ADDR) begin
            state_d    = ST_READY;
            clr_addr_d = '0;
         end else begin
            clr_addr_d = clr_addr_q + 1'b1;
         end
      end else if (clear) begin
         state_d    = ST_CLEAR;
         clr_addr_d = '0;
      end
   end

   // The sweep write is suppressed while reset is held so it restarts cleanly.
   always_comb begin
      busy     = (state_q == ST_CLEAR);
      clr_we   = busy & ~reset;
      clr_addr = clr_addr_q;
   end

endmodule : ram_clear_seq
`default_nettype wire

// File: rtl/ram_param.sv
`default_nettype none
// ============================================================================
// Module   : ram_param
// Brief    : Parametrised single-clock RAM with registered read, valid strobe,
//            optional output register and hardware clear sequencer.
// Revision : 1.0
// ============================================================================
module ram_param
   import ram_pkg::*;
#(
   parameter int WIDTH   = RAM_WIDTH_DEF,
   parameter int ADDR_W  = RAM_ADDR_W_DEF,
   parameter int DEPTH   = 2**ADDR_W,
   parameter int OUT_REG = 0
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              load,
   input  logic [ADDR_W-1:0] address,
   input  logic [WIDTH-1:0]  in,
   input  logic              rd_en,
   output logic [WIDTH-1:0]  out,
   output logic              out_valid,
   output logic              busy
);

   localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

   logic [WIDTH-1:0]  mem_q [DEPTH];

   logic              seq_busy;
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;

   logic              in_range;
   logic              accept;
   logic              user_we;
   logic              rd_fire;
   logic              mem_we;
   logic [IDX_W-1:0]  wr_idx;
   logic [WIDTH-1:0]  wr_data;
   logic [WIDTH-1:0]  rd_data;

   logic [WIDTH-1:0]  out_q, out_d;
   logic              out_valid_q, out_valid_d;

   ram_clear_seq #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_clear_seq (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .busy     (seq_busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   always_comb begin
      in_range = ({1'b0, address} < DEPTH_C);
      accept   = ~seq_busy & ~clear & ~reset;
      user_we  = accept & load & in_range;
      rd_fire  = accept & rd_en;
      mem_we   = clr_we | user_we;
      wr_idx   = clr_we ? clr_addr[IDX_W-1:0] : address[IDX_W-1:0];
      wr_data  = clr_we ? '0 : in;
   end

   // Write-first: a same-cycle load forwards the write data to the read.
   always_comb begin
      rd_data = '0;
      if (in_range) begin
         rd_data = load ? in : mem_q[address[IDX_W-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_idx] <= wr_data;
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [WIDTH-1:0] pipe_data_q, pipe_data_d;
         logic             pipe_valid_q, pipe_valid_d;

         always_comb begin
            pipe_valid_d = rd_fire;
            pipe_data_d  = rd_fire ? rd_data : pipe_data_q;
            // A clear request kills the read waiting in the pipeline stage.
            out_valid_d  = pipe_valid_q & ~clear;
            out_d        = out_valid_d ? pipe_data_q : out_q;
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               pipe_valid_q <= 1'b0;
               pipe_data_q  <= '0;
            end else begin
               pipe_valid_q <= pipe_valid_d;
               pipe_data_q  <= pipe_data_d;
            end
         end
      end else begin : g_no_out_reg
         always_comb begin
            out_valid_d = rd_fire;
            out_d       = rd_fire ? rd_data : out_q;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      out       = out_q;
      out_valid = out_valid_q;
      busy      = seq_busy;
   end

endmodule : ram_param
`default_nettype wire

// File: tb/tb_ram_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_param
// Brief    : Scoreboard bench driving three ram_param variants in lock-step.
// Revision : 1.0
// ============================================================================
module tb_ram_param;

   typedef struct {
      logic [15:0] data;
      int          cyc;
   } exp_t;

   logic        clk     = 1'b0;
   logic        reset   = 1'b1;
   logic        clear   = 1'b0;
   logic        load    = 1'b0;
   logic        rd_en   = 1'b0;
   logic [3:0]  address = '0;
   logic [15:0] in      = '0;

   logic [15:0] out0, out1, out2;
   logic        v0, v1, v2;
   logic        b0, b1, b2;

   int   cycle  = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q0[$], q1[$], q2[$];
   exp_t e0, e1, e2;

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   // dut0: latency 1, dut1: latency 2, dut2: 12 words in a 4-bit address space
   ram_param #(.WIDTH(16), .ADDR_W(4), .DEPTH(16), .OUT_REG(0)) dut0 (
      .clk(clk), .reset(reset), .clear(clear), .load(load), .address(address),
      .in(in), .rd_en(rd_en), .out(out0), .out_valid(v0), .busy(b0));
   ram_param #(.WIDTH(16), .ADDR_W(4), .DEPTH(16), .OUT_REG(1)) dut1 (
      .clk(clk), .reset(reset), .clear(clear), .load(load), .address(address),
      .in(in), .rd_en(rd_en), .out(out1), .out_valid(v1), .busy(b1));
   ram_param #(.WIDTH(16), .ADDR_W(4), .DEPTH(12), .OUT_REG(0)) dut2 (
      .clk(clk), .reset(reset), .clear(clear), .load(load), .address(address),
      .in(in), .rd_en(rd_en), .out(out2), .out_valid(v2), .busy(b2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (v0) begin
         if (q0.size() == 0) chk("dut0 spurious out_valid", 32'd1, 32'd0);
         else begin
            e0 = q0.pop_front();
            chk("dut0 data", {16'h0, out0}, {16'h0, e0.data});
            chk("dut0 latency", cycle, e0.cyc);
         end
      end
   end

   always @(negedge clk) begin
      if (v1) begin
         if (q1.size() == 0) chk("dut1 spurious out_valid", 32'd1, 32'd0);
         else begin
            e1 = q1.pop_front();
            chk("dut1 data", {16'h0, out1}, {16'h0, e1.data});
            chk("dut1 latency", cycle, e1.cyc);
         end
      end
   end

   always @(negedge clk) begin
      if (v2) begin
         if (q2.size() == 0) chk("dut2 spurious out_valid", 32'd1, 32'd0);
         else begin
            e2 = q2.pop_front();
            chk("dut2 data", {16'h0, out2}, {16'h0, e2.data});
            chk("dut2 latency", cycle, e2.cyc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      load  = 1'b0;
      rd_en = 1'b0;
      clear = 1'b0;
      repeat (n) step();
   endtask

   task automatic push(input logic [15:0] e01, input logic [15:0] e2v, input bit p1);
      q0.push_back('{data: e01, cyc: cycle + 1});
      if (p1) q1.push_back('{data: e01, cyc: cycle + 2});
      q2.push_back('{data: e2v, cyc: cycle + 1});
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d);
      load = 1'b1; rd_en = 1'b0; address = a; in = d;
      step();
      load = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, input logic [15:0] e01, input logic [15:0] e2v);
      load = 1'b0; rd_en = 1'b1; address = a;
      push(e01, e2v, 1'b1);
      step();
      rd_en = 1'b0;
   endtask

   task automatic rdwr(input logic [3:0] a, input logic [15:0] d,
                       input logic [15:0] e01, input logic [15:0] e2v);
      load = 1'b1; rd_en = 1'b1; address = a; in = d;
      push(e01, e2v, 1'b1);
      step();
      load = 1'b0; rd_en = 1'b0;
   endtask

   // Counts busy cycles starting with the cycle after the triggering edge.
   task automatic count_busy(input string tag);
      int c0, c1, c2;
      c0 = 0; c1 = 0; c2 = 0;
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         c0 += int'(b0);
         c1 += int'(b1);
         c2 += int'(b2);
      end
      chk({tag, " busy cycles dut0"}, c0, 16);
      chk({tag, " busy cycles dut1"}, c1, 16);
      chk({tag, " busy cycles dut2"}, c2, 12);
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state and the initial clear sweep
      step(); step();
      chk("reset busy", {29'h0, b0, b1, b2}, 32'h7);
      chk("reset out_valid", {29'h0, v0, v1, v2}, 32'h0);
      chk("reset out dut0", {16'h0, out0}, 32'h0);
      chk("reset out dut1", {16'h0, out1}, 32'h0);
      reset = 1'b0;
      count_busy("post-reset");
      for (int i = 0; i < 16; i++) rd(4'(i), 16'h0000, 16'h0000);
      idle(3);

      // Plain write then read
      wr(4'd3, 16'hBEEF);
      rd(4'd3, 16'hBEEF, 16'hBEEF);
      idle(3);

      // Same-cycle write and read returns the new data
      rdwr(4'd5, 16'h1234, 16'h1234, 16'h1234);
      idle(3);

      // Out-of-range on the 12-deep instance
      wr(4'd11, 16'h0B11);
      wr(4'd14, 16'h5555);
      rd(4'd14, 16'h5555, 16'h0000);
      rd(4'd11, 16'h0B11, 16'h0B11);
      rdwr(4'd13, 16'h7777, 16'h7777, 16'h0000);
      idle(3);

      // Fill, then clear with requests that must be dropped
      for (int i = 0; i < 16; i++) wr(4'(i), 16'hA000 + 16'(i));
      rd(4'd0, 16'hA000, 16'hA000);
      rd(4'd15, 16'hA00F, 16'h0000);
      rd(4'd11, 16'hA00B, 16'hA00B);
      idle(3);
      load = 1'b0; rd_en = 1'b1; address = 4'd7;
      push(16'hA007, 16'hA007, 1'b0);
      step();
      clear = 1'b1; load = 1'b1; rd_en = 1'b1; address = 4'd2; in = 16'hDEAD;
      step();
      clear = 1'b0;
      chk("dut1 out held after dropped read", {16'h0, out1}, 32'h0000A00B);
      fork
         count_busy("clear");
         begin
            load = 1'b1; rd_en = 1'b1; address = 4'd4; in = 16'hDEAD;
            repeat (5) step();
            load = 1'b0; rd_en = 1'b0;
         end
      join
      idle(2);
      for (int i = 0; i < 16; i++) rd(4'(i), 16'h0000, 16'h0000);
      idle(3);

      // Reset mid-sweep restarts the clear; out held through clear, zeroed by reset
      wr(4'd1, 16'h00C3);
      rd(4'd1, 16'h00C3, 16'h00C3);
      idle(3);
      clear = 1'b1;
      step();
      clear = 1'b0;
      step();
      chk("out held during clear dut0", {16'h0, out0}, 32'h000000C3);
      chk("out held during clear dut2", {16'h0, out2}, 32'h000000C3);
      repeat (6) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("out zeroed by reset dut0", {16'h0, out0}, 32'h0);
      chk("out zeroed by reset dut1", {16'h0, out1}, 32'h0);
      count_busy("reset mid-clear");
      rd(4'd1, 16'h0000, 16'h0000);
      idle(4);

      chk("dut0 scoreboard drained", q0.size(), 0);
      chk("dut1 scoreboard drained", q1.size(), 0);
      chk("dut2 scoreboard drained", q2.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_ram_param
`default_nettype wire
